// File: rtl/array_port_ctrl_if.sv
// Request/response and SRAM RW0 bundle for array_port_ctrl.
// The slave modport is the controller's view; the master modport is the
// environment's view (requester, response consumer and SRAM macro together).
interface array_port_ctrl_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 100,
    parameter int LANES  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LANES-1:0]  req_mask;
    logic [DATA_W-1:0] req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;

    logic              init_done;

    logic [ADDR_W-1:0] sram_addr;
    logic              sram_en;
    logic              sram_wmode;
    logic [LANES-1:0]  sram_wmask;
    logic [DATA_W-1:0] sram_wdata;
    logic [DATA_W-1:0] sram_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_mask, req_wdata,
        input  resp_ready, sram_rdata,
        output req_ready, resp_valid, resp_data, init_done,
        output sram_addr, sram_en, sram_wmode, sram_wmask, sram_wdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_mask, req_wdata,
        output resp_ready, sram_rdata,
        input  req_ready, resp_valid, resp_data, init_done,
        input  sram_addr, sram_en, sram_wmode, sram_wmask, sram_wdata
    );
endinterface

// File: rtl/array_port_ctrl.sv
// Request controller for a single-port, lane-masked SRAM with a 1-cycle
// registered read. Optionally zero-fills the array after reset, then passes
// requests straight to the SRAM and returns read data through a small FIFO.
// Read credits (FIFO entries + read in flight) gate req_ready so the FIFO can
// never overflow, since SRAM read data is only valid for one cycle.
module array_port_ctrl #(
    parameter int ADDR_W        = 7,
    parameter int DATA_W        = 100,
    parameter int LANES         = 4,
    parameter int RESP_DEPTH    = 3,
    parameter int INIT_ON_RESET = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    array_port_ctrl_if.slave bus
);
    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);

    localparam logic [CNT_W:0]    DEPTH_C     = (CNT_W + 1)'(RESP_DEPTH);
    localparam logic [CNT_W-1:0]  FULL_C      = CNT_W'(RESP_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE_C   = CNT_W'(1);
    localparam logic [PTR_W-1:0]  LAST_PTR_C  = PTR_W'(RESP_DEPTH - 1);
    localparam logic [PTR_W-1:0]  PTR_ONE_C   = PTR_W'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR_C = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE_C  = ADDR_W'(1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam state_t RESET_STATE_C = (INIT_ON_RESET != 0) ? ST_INIT : ST_RUN;

    // Circular pointer advance over RESP_DEPTH entries (depth need not be a power of two).
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == LAST_PTR_C) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + PTR_ONE_C;
        end
        return nxt;
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
    logic              inflight_q, inflight_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DATA_W-1:0] fifo_q [RESP_DEPTH];
    logic [DATA_W-1:0] fifo_d [RESP_DEPTH];

    logic              run_s;
    logic [CNT_W:0]    occ_s;
    logic              req_ready_s;
    logic              fire_s;
    logic              rd_fire_s;
    logic              resp_valid_s;
    logic              full_s;
    logic              push_s;
    logic              pop_s;

    logic [ADDR_W-1:0] sram_addr_s;
    logic              sram_en_s;
    logic              sram_wmode_s;
    logic [LANES-1:0]  sram_wmask_s;
    logic [DATA_W-1:0] sram_wdata_s;

    // Handshake qualifiers; reset_n gating keeps every control output low while reset is held.
    always_comb begin
        run_s        = (state_q == ST_RUN) & reset_n;
        occ_s        = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
        req_ready_s  = run_s & (occ_s < DEPTH_C);
        fire_s       = bus.req_valid & req_ready_s;
        rd_fire_s    = fire_s & ~bus.req_write;
        resp_valid_s = (count_q != {CNT_W{1'b0}});
        full_s       = (count_q == FULL_C);
        pop_s        = resp_valid_s & bus.resp_ready;
        // Read data from the SRAM is valid only in the cycle after the accept.
        push_s       = inflight_q & (~full_s | pop_s);
        inflight_d   = rd_fire_s;
    end

    // Next state: walk the init counter over every address, then run forever.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            ST_INIT: begin
                init_cnt_d = init_cnt_q + ADDR_ONE_C;
                if (init_cnt_q == LAST_ADDR_C) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                state_d    = ST_RUN;
                init_cnt_d = init_cnt_q;
            end
            default: begin
                state_d    = RESET_STATE_C;
                init_cnt_d = {ADDR_W{1'b0}};
            end
        endcase
    end

    // SRAM drive: zero-fill writes during init, request pass-through in run.
    always_comb begin
        sram_en_s    = 1'b0;
        sram_wmode_s = bus.req_write;
        sram_addr_s  = bus.req_addr;
        sram_wmask_s = bus.req_mask;
        sram_wdata_s = bus.req_wdata;
        case (state_q)
            ST_INIT: begin
                sram_en_s    = reset_n;
                sram_wmode_s = 1'b1;
                sram_addr_s  = init_cnt_q;
                sram_wmask_s = {LANES{1'b1}};
                sram_wdata_s = {DATA_W{1'b0}};
            end
            ST_RUN: begin
                sram_en_s = fire_s;
            end
            default: begin
                sram_en_s = 1'b0;
            end
        endcase
    end

    // Response FIFO bookkeeping: capture at the tail, present the head.
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        fifo_d   = fifo_q;
        if (push_s) begin
            fifo_d[wr_ptr_q] = bus.sram_rdata;
            wr_ptr_d         = next_ptr(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE_C;
            2'b01:   count_d = count_q - CNT_ONE_C;
            default: count_d = count_q;
        endcase
    end

    // State, credit and FIFO registers; reset drops all pending responses.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RESET_STATE_C;
            init_cnt_q <= {ADDR_W{1'b0}};
            inflight_q <= 1'b0;
            count_q    <= {CNT_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            wr_ptr_q   <= {PTR_W{1'b0}};
            for (int i = 0; i < RESP_DEPTH; i++) begin
                fifo_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            for (int i = 0; i < RESP_DEPTH; i++) begin
                fifo_q[i] <= fifo_d[i];
            end
        end
    end

    assign bus.req_ready  = req_ready_s;
    assign bus.resp_valid = resp_valid_s;
    assign bus.resp_data  = fifo_q[rd_ptr_q];
    assign bus.init_done  = run_s;
    assign bus.sram_addr  = sram_addr_s;
    assign bus.sram_en    = sram_en_s;
    assign bus.sram_wmode = sram_wmode_s;
    assign bus.sram_wmask = sram_wmask_s;
    assign bus.sram_wdata = sram_wdata_s;
endmodule

// File: tb/tb_array_port_ctrl.sv
// Bench for array_port_ctrl: SRAM macro model, behavioural reference
// (array contents + queue of outstanding reads), per-cycle compare and
// directed plus randomized stimulus.
module tb_array_port_ctrl;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 100;
    localparam int LANES      = 4;
    localparam int LANE_W     = 25;
    localparam int RESP_DEPTH = 3;
    localparam int DEPTH      = 128;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                acc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    array_port_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANES(LANES)) bus ();

    array_port_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LANES(LANES),
        .RESP_DEPTH(RESP_DEPTH), .INIT_ON_RESET(1)
    ) dut (
        .clock  (clk),
        .reset_n(rst_n),
        .bus    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0] sram_mem [DEPTH];
    logic [DATA_W-1:0] sram_rd;
    logic [DATA_W-1:0] ref_mem  [DEPTH];
    exp_t              exp_q[$];
    logic [DATA_W-1:0] seen_q[$];

    function automatic void chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chkw(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chk_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                                 input logic [LANES-1:0] m,
                                                 input logic [DATA_W-1:0] d);
        logic [DATA_W-1:0] r;
        r = old;
        for (int l = 0; l < LANES; l++) begin
            if (m[l]) r[l*LANE_W +: LANE_W] = d[l*LANE_W +: LANE_W];
        end
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] rand_data();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[DATA_W-1:0];
    endfunction

    // SRAM macro model: masked write, registered-address read with 1-cycle latency.
    assign bus.sram_rdata = sram_rd;
    initial begin : sram_model
        for (int i = 0; i < DEPTH; i++) sram_mem[i] = rand_data();
        sram_rd = rand_data();
        forever begin
            @(posedge clk);
            if (bus.sram_en === 1'b1) begin
                if (bus.sram_wmode) sram_mem[bus.sram_addr] <= merge(sram_mem[bus.sram_addr], bus.sram_wmask, bus.sram_wdata);
                else                sram_rd <= sram_mem[bus.sram_addr];
            end
        end
    end

    // Reference model and per-cycle compare, evaluated mid-cycle.
    initial begin : model
        logic run_e, ready_e, rv_e, fire_e;
        int   cyc;
        int   since_rst;
        cyc = 0;
        since_rst = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                chk1("rst_req_ready", bus.req_ready, 1'b0);
                chk1("rst_resp_valid", bus.resp_valid, 1'b0);
                chk1("rst_init_done", bus.init_done, 1'b0);
                chk1("rst_sram_en", bus.sram_en, 1'b0);
                exp_q.delete();
                since_rst = 0;
            end else begin
                run_e   = (since_rst >= DEPTH);
                ready_e = run_e && (exp_q.size() < RESP_DEPTH);
                rv_e    = (exp_q.size() > 0) && (cyc >= exp_q[0].acc + 2);
                chk1("req_ready", bus.req_ready, ready_e);
                chk1("resp_valid", bus.resp_valid, rv_e);
                chk1("init_done", bus.init_done, run_e);
                if (rv_e) chkw("resp_data", bus.resp_data, exp_q[0].data);
                if (bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) seen_q.push_back(bus.resp_data);
                if (!run_e) begin
                    chk1("init_en", bus.sram_en, 1'b1);
                    chk1("init_wmode", bus.sram_wmode, 1'b1);
                    chk_int("init_wmask", int'(bus.sram_wmask), 15);
                    chkw("init_wdata", bus.sram_wdata, '0);
                    chk_int("init_addr", int'(bus.sram_addr), since_rst);
                    ref_mem[since_rst] = '0;
                    since_rst++;
                end else begin
                    fire_e = bus.req_valid && ready_e;
                    chk1("sram_en", bus.sram_en, fire_e);
                    if (fire_e) begin
                        chk_int("sram_addr", int'(bus.sram_addr), int'(bus.req_addr));
                        chk1("sram_wmode", bus.sram_wmode, bus.req_write);
                        if (bus.req_write) begin
                            chk_int("sram_wmask", int'(bus.sram_wmask), int'(bus.req_mask));
                            chkw("sram_wdata", bus.sram_wdata, bus.req_wdata);
                        end
                    end
                    if (rv_e && bus.resp_ready) void'(exp_q.pop_front());
                    if (fire_e) begin
                        if (bus.req_write) ref_mem[bus.req_addr] = merge(ref_mem[bus.req_addr], bus.req_mask, bus.req_wdata);
                        else exp_q.push_back('{data: ref_mem[bus.req_addr], acc: cyc});
                    end
                end
            end
            cyc++;
        end
    end

    // Drive one request and hold it until accepted (bounded).
    task automatic issue(input logic w, input logic [ADDR_W-1:0] a,
                         input logic [LANES-1:0] m, input logic [DATA_W-1:0] d);
        logic acc;
        int   t;
        acc = 1'b0;
        t   = 0;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_mask  = m;
        bus.req_wdata = d;
        while (!acc && t < 200) begin
            @(negedge clk);
            acc = bus.req_ready;
            @(posedge clk);
            #1;
            t++;
        end
        bus.req_valid = 1'b0;
        chk1("issue_accept", acc, 1'b1);
    endtask

    // Wait (bounded) until k responses have been consumed.
    task automatic wait_seen(input int k);
        int t;
        t = 0;
        while (seen_q.size() < k && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        chk_int("resp_count", seen_q.size(), k);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int               n, acc_n, stalls, t;
        logic             hit;
        logic [24:0]      v;
        logic [DATA_W-1:0] ones, pat_aa, pat_55, exp_w;
        ones   = {DATA_W{1'b1}};
        pat_aa = {25{4'hA}};
        pat_55 = {25{4'h5}};

        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_mask   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b1;

        // Reset and zero-fill.
        repeat (3) @(posedge clk);
        #1;
        chk1("hold_rst_ready", bus.req_ready, 1'b0);
        chk1("hold_rst_init_done", bus.init_done, 1'b0);
        rst_n = 1'b1;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (bus.req_ready) break;
            n++;
        end
        chk_int("init_cycles", n, 128);
        chk1("init_done_after", bus.init_done, 1'b1);
        @(posedge clk);
        #1;
        seen_q.delete();
        issue(1'b0, 7'd0, 4'h0, '0);
        issue(1'b0, 7'd64, 4'h0, '0);
        issue(1'b0, 7'd127, 4'h0, '0);
        wait_seen(3);
        for (int i = 0; i < 3; i++) chkw("zero_fill_read", seen_q[i], '0);

        // Masked write then read, with latency check.
        issue(1'b1, 7'd5, 4'b0101, ones);
        issue(1'b0, 7'd5, 4'h0, '0);
        @(negedge clk);
        chk1("lat_first_cycle", bus.resp_valid, 1'b0);
        @(negedge clk);
        chk1("lat_second_cycle", bus.resp_valid, 1'b1);
        exp_w = {25'h0, 25'h1FFFFFF, 25'h0, 25'h1FFFFFF};
        chkw("masked_read", bus.resp_data, exp_w);
        @(posedge clk);
        #1;

        // Credit limit with resp_ready low.
        for (int i = 0; i < 5; i++) begin
            v = 25'(i + 1);
            issue(1'b1, 7'(10 + i), 4'hF, {4{v}});
        end
        repeat (3) @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_write  = 1'b0;
        bus.req_addr   = 7'd10;
        acc_n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            hit = bus.req_ready;
            @(posedge clk);
            #1;
            if (hit) begin
                acc_n++;
                bus.req_addr = bus.req_addr + 7'd1;
            end
        end
        chk_int("credit_accepts", acc_n, 3);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk1("credit_ready_low", bus.req_ready, 1'b0);
            chk1("hold_valid", bus.resp_valid, 1'b1);
            chkw("hold_data", bus.resp_data, {4{25'd1}});
        end
        @(posedge clk);
        #1;
        seen_q.delete();
        bus.resp_ready = 1'b1;
        t = 0;
        while (acc_n < 5 && t < 50) begin
            @(negedge clk);
            hit = bus.req_ready;
            @(posedge clk);
            #1;
            if (hit) begin
                acc_n++;
                bus.req_addr = bus.req_addr + 7'd1;
            end
            t++;
        end
        bus.req_valid = 1'b0;
        chk_int("credit_total", acc_n, 5);
        wait_seen(5);
        for (int i = 0; i < 5; i++) begin
            v = 25'(i + 1);
            chkw("credit_order", seen_q[i], {4{v}});
        end

        // Read/write hazards on one address.
        seen_q.delete();
        issue(1'b1, 7'd20, 4'hF, pat_aa);
        issue(1'b0, 7'd20, 4'h0, '0);
        issue(1'b1, 7'd20, 4'hF, pat_55);
        issue(1'b0, 7'd20, 4'h0, '0);
        wait_seen(2);
        chkw("hazard_first", seen_q[0], pat_aa);
        chkw("hazard_second", seen_q[1], pat_55);

        // Random writes, then 100 back-to-back reads with resp_ready high.
        for (int i = 0; i < 40; i++) begin
            issue(1'b1, 7'($urandom_range(0, DEPTH - 1)), 4'($urandom_range(0, 15)), rand_data());
        end
        repeat (4) @(posedge clk);
        #1;
        stalls = 0;
        bus.req_write = 1'b0;
        for (int i = 0; i < 100; i++) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = 7'($urandom_range(0, DEPTH - 1));
            @(negedge clk);
            if (!bus.req_ready) stalls++;
            @(posedge clk);
            #1;
        end
        bus.req_valid = 1'b0;
        chk_int("b2b_stalls", stalls, 0);

        // Random mixed traffic with random backpressure, narrow address range.
        for (int i = 0; i < 400; i++) begin
            bus.req_valid  = 1'($urandom_range(0, 1));
            bus.req_write  = 1'($urandom_range(0, 1));
            bus.req_addr   = 7'($urandom_range(0, 15));
            bus.req_mask   = 4'($urandom_range(0, 15));
            bus.req_wdata  = rand_data();
            bus.resp_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk);
            #1;
        end
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        // Reset with two responses queued and one read in flight.
        bus.resp_ready = 1'b0;
        issue(1'b0, 7'd5, 4'h0, '0);
        issue(1'b0, 7'd20, 4'h0, '0);
        issue(1'b0, 7'd10, 4'h0, '0);
        chk1("pre_reset_valid", bus.resp_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("reset_drops_valid", bus.resp_valid, 1'b0);
        chk1("reset_drops_ready", bus.req_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen_q.delete();
        bus.resp_ready = 1'b1;
        t = 0;
        while (!bus.init_done && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk1("reinit_done", bus.init_done, 1'b1);
        repeat (5) @(negedge clk);
        chk_int("no_stale_resp", seen_q.size(), 0);
        chk1("no_stale_valid", bus.resp_valid, 1'b0);
        @(posedge clk);
        #1;
        issue(1'b0, 7'd20, 4'h0, '0);
        wait_seen(1);
        chkw("reinit_zero", seen_q[0], '0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/array_port_ctrl.md
Name: array_port_ctrl

Overview:
Request controller that sits directly upstream of the 128x100 single-port masked-write SRAM macro. The SRAM has 4 write lanes of 25 bits and registered-address read with 1-cycle latency.
- Accepts read/write requests on a valid/ready interface and drives the SRAM RW0 port.
- Captures read data in the only cycle it is guaranteed valid and returns it through a backpressurable response FIFO.
- Optionally zero-fills the array after reset before accepting traffic.

Parameters:
ADDR_W, 7, SRAM address width (depth = 2^ADDR_W = 128)
DATA_W, 100, SRAM data width
LANES, 4, write-mask lanes; lane width = DATA_W/LANES = 25
RESP_DEPTH, 3, response FIFO entries; legal range >= 2
INIT_ON_RESET, 1, 1 = zero-fill whole array after reset; 0 = go straight to RUN

Ports:
clock  in  1  single clock; also drives the SRAM clock
reset_n  in  1  asynchronous, active-low reset
req_valid  in  1  request valid
req_ready  out  1  request accepted when valid & ready at posedge
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  request address
req_mask  in  LANES  write lane enables; ignored for reads
req_wdata  in  DATA_W  write data
resp_valid  out  1  read response valid
resp_ready  in  1  consumer accepts response
resp_data  out  DATA_W  read data, FIFO head
init_done  out  1  high once RUN is reached
sram_addr  out  ADDR_W  to SRAM RW0_addr
sram_en  out  1  to SRAM RW0_en
sram_wmode  out  1  to SRAM RW0_wmode
sram_wmask  out  LANES  to SRAM RW0_wmask
sram_wdata  out  DATA_W  to SRAM RW0_wdata
sram_rdata  in  DATA_W  from SRAM RW0_rdata

Behaviour:
- Reset (async assert, any cycle): state = INIT (or RUN if INIT_ON_RESET=0), init counter = 0, FIFO empty, in-flight flag = 0. req_ready = 0, resp_valid = 0, init_done = 0, sram_en = 0. SRAM contents are not touched by reset. Reset mid-init or mid-read drops all pending responses.
- State INIT:
  - Each cycle drive sram_en=1, sram_wmode=1, sram_wmask=all ones, sram_wdata=0, sram_addr=counter.
  - Counter increments; after address 2^ADDR_W-1 is written, go to RUN.
  - Takes 128 cycles. req_ready=0 throughout.
- State RUN:
  - init_done=1.
  - req_ready = (fifo_count + inflight) < RESP_DEPTH. It is registered-state only and has no combinational path from req_* or resp_ready.
  - SRAM drive is combinational pass-through: sram_en = req_valid & req_ready, sram_wmode = req_write, sram_addr/wmask/wdata = req_*.
  - When sram_en=0, sram_addr/wdata are don't-care but must not be X after reset; drive req_* through.
- Reads:
  - Accepted at edge E: inflight=1 for the following cycle.
  - sram_rdata is sampled into the FIFO tail at edge E+1, with no other condition.
  - resp_valid rises the cycle after E+1. Read-to-response latency is 2 cycles.
  - inflight clears at E+1 unless another read is accepted at E+1.
- Writes:
  - Complete at the accepting edge; no response.
  - Lanes with mask bit 0 are unchanged; mask=0 is a legal no-op write.
- FIFO:
  - In-order, depth RESP_DEPTH. Pop on resp_valid & resp_ready.
  - Simultaneous push and pop keeps the count unchanged.
  - The credit rule guarantees no push when full. An overflow is a design error; the bench asserts it never happens.
  - With RESP_DEPTH=3 and resp_ready held high, back-to-back reads sustain 1 per cycle.
- Hazards:
  - Write to A at E, then read of A at E+1: returns the new data.
  - Read of A at E, then write of A at E+1: returns the old data. The capture at E+1 samples before the write takes effect.
- resp_data holds steady while resp_valid=1 and resp_ready=0.

Test Plan:
- Reset release with INIT_ON_RESET=1 -> req_ready=0 for exactly 128 cycles, sram_wmask=4'hF and wdata=0 at each address 0..127, then init_done=1; reads of addresses 0, 64 and 127 return 0.
- Write addr 5, mask 4'b0101, data all ones, then read addr 5 -> resp_data = lanes 0 and 2 all ones, lanes 1 and 3 zero, resp_valid 2 cycles after the read accept.
- Hold resp_ready=0 and issue 5 reads -> exactly 3 accepted, then req_ready=0. Release resp_ready -> 3 responses in order with unchanged data, then the remaining reads are accepted.
- Back-to-back: write A=0x..AA at cycle 0, read A at 1, write A=0x..55 at 2, read A at 2 is not possible so read A at 3 -> responses are 0x..AA then 0x..55.
- 100 random reads with resp_ready=1 and RESP_DEPTH=3 -> one accept per cycle sustained, data matches the scoreboard.
- Assert reset_n low with 2 responses queued and 1 in flight -> resp_valid=0 immediately, no stale response after re-init completes.
